// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_pkg
// Description : ALU control codes, ALUOp classes and EX-unit state encodings
//               shared by the ALU control decoder and the execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_unit_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_XOR  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_ADD  = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_MUL  = 4'b0101,
        ALU_ADDI = 4'b0110,
        ALU_SRAI = 4'b0111,
        ALU_LW   = 4'b1000,
        ALU_SW   = 4'b1001
    } alu_ctrl_e;

    // ALUOp classes produced by the main decoder.
    localparam logic [1:0] c_ALUOP_LDST   = 2'b00;
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] c_ALUOP_ITYPE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    function automatic logic is_illegal_code(input logic [3:0] code);
        return (code >= 4'b1010);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative shift-add multiplier, one multiplier bit per cycle,
//               returning the low WIDTH bits of the product.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int c_CNT_W = $clog2(WIDTH);

    logic               busy_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   w_acc_d;
    logic               w_last;

    assign w_acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_last  = (cnt_q == c_CNT_W'(WIDTH - 1));

    // The final partial sum is presented combinationally so the caller can
    // capture the product on the same edge that retires the last bit.
    assign done_o    = busy_q && w_last;
    assign product_o = w_acc_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= w_acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + c_CNT_W'(1);
            if (w_last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : EX-stage ALU with valid/ready handshake; single-cycle ops are
//               registered, MUL uses the iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_illegal;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [WIDTH-1:0]   w_mul_product;

    assign w_shamt     = src2_i[SHAMT_W-1:0];
    assign ready_o     = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i);
    assign w_accept    = valid_i && ready_o;
    assign w_is_mul    = (ALUCtrl_i == ALU_MUL);
    assign w_illegal   = is_illegal_code(ALUCtrl_i);
    assign w_mul_start = w_accept && w_is_mul;

    // Illegal codes fall through to the default and yield zero.
    always_comb begin
        w_alu_res = '0;
        case (alu_ctrl_e'(ALUCtrl_i))
            ALU_AND:                           w_alu_res = src1_i & src2_i;
            ALU_XOR:                           w_alu_res = src1_i ^ src2_i;
            ALU_SLL:                           w_alu_res = src1_i << w_shamt;
            ALU_ADD, ALU_ADDI, ALU_LW, ALU_SW: w_alu_res = src1_i + src2_i;
            ALU_SUB:                           w_alu_res = src1_i - src2_i;
            ALU_SRAI:                          w_alu_res = $signed(src1_i) >>> w_shamt;
            default:                           w_alu_res = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (w_mul_start),
        .a_i      (src1_i),
        .b_i      (src2_i),
        .done_o   (w_mul_done),
        .product_o(w_mul_product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && ready_i) begin
                    state_d = ST_IDLE;
                end
                // A DONE-state accept consumes the pending result on the same edge.
                if (w_accept) begin
                    if (w_is_mul) begin
                        state_d = ST_MUL_BUSY;
                    end else begin
                        state_d   = ST_DONE;
                        result_d  = w_alu_res;
                        zero_d    = (w_alu_res == '0);
                        illegal_d = w_illegal;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (w_mul_done) begin
                    state_d   = ST_DONE;
                    result_d  = w_mul_product;
                    zero_d    = (w_mul_product == '0);
                    illegal_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o   = (state_q == ST_DONE);
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit with an
//               expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    alu_exec_unit #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ALUCtrl_i(ALUCtrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic z, input logic ill);
        exp_t e;
        e.res = res;
        e.z   = z;
        e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, " valid_o"}, {31'b0, valid_o}, 32'd1);
        chk({tag, " sb_depth"}, sb.size(), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " result_o"}, result_o, e.res);
            chk({tag, " zero_o"}, {31'b0, zero_o}, {31'b0, e.z});
            chk({tag, " illegal_o"}, {31'b0, illegal_o}, {31'b0, e.ill});
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i   = v;
        ALUCtrl_i = op;
        src1_i    = a;
        src2_i    = b;
    endtask

    initial begin
        logic [3:0]  ops [8];
        logic [31:0] as  [8];
        logic [31:0] bs  [8];
        logic [31:0] exs [8];
        string       tags[8];
        int          busy_bad;
        int          early;
        int          rises;

        ops  = '{ALU_SUB, ALU_SRAI, ALU_SLL, ALU_AND, ALU_XOR, ALU_LW, ALU_SW, ALU_SLL};
        as   = '{32'd5, 32'h8000_0000, 32'd1, 32'h0000_F0F0, 32'd7, 32'h0000_1000, 32'hFFFF_FFFF, 32'd3};
        bs   = '{32'd7, 32'd4, 32'd31, 32'h0000_0FF0, 32'd7, 32'h0000_0020, 32'd1, 32'd35};
        exs  = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h8000_0000, 32'h0000_00F0, 32'h0,
                 32'h0000_1020, 32'h0, 32'h0000_0018};
        tags = '{"sub", "srai", "sll31", "and", "xor", "lw", "sw_wrap", "sll_shamt_mask"};

        // Reset held two cycles with a live request on the inputs.
        rst_i   = 1'b0;
        ready_i = 1'b1;
        drive(1'b1, ALU_ADD, 32'd1, 32'd2);
        tick();
        tick();
        chk("rst valid_o", {31'b0, valid_o}, 32'd0);
        chk("rst result_o", result_o, 32'd0);
        chk("rst zero_o", {31'b0, zero_o}, 32'd1);
        chk("rst illegal_o", {31'b0, illegal_o}, 32'd0);
        rst_i = 1'b1;
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        #1;
        chk("rst ready_o", {31'b0, ready_o}, 32'd1);

        // Back-to-back single-cycle ops, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            #1;
            chk({tags[i], " ready_o"}, {31'b0, ready_o}, 32'd1);
            push(exs[i], (exs[i] == 32'h0), 1'b0);
            tick();
            check_result(tags[i]);
        end
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();
        chk("b2b drain valid_o", {31'b0, valid_o}, 32'd0);

        // MUL latency, busy ready_o and ignored requests while busy.
        drive(1'b1, ALU_MUL, 32'h0001_0001, 32'h0001_0001);
        #1;
        chk("mul accept ready_o", {31'b0, ready_o}, 32'd1);
        push(32'h0002_0001, 1'b0, 1'b0);
        tick();
        chk("mul edge1 valid_o", {31'b0, valid_o}, 32'd0);
        busy_bad = 0;
        early    = 0;
        for (int k = 2; k <= 33; k++) begin
            drive(k[0], ALU_ADD, 32'(k), 32'd100);
            #1;
            if (ready_o !== 1'b0) busy_bad++;
            tick();
            if (k < 33 && valid_o !== 1'b0) early++;
        end
        chk("mul busy ready_o", busy_bad, 32'd0);
        chk("mul early valid_o", early, 32'd0);
        check_result("mul");
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();
        chk("mul no extra valid_o", {31'b0, valid_o}, 32'd0);

        // Backpressure hold, then accept on the edge ready_i rises.
        ready_i = 1'b0;
        drive(1'b1, ALU_ADD, 32'd3, 32'd4);
        push(32'd7, 1'b0, 1'b0);
        tick();
        drive(1'b0, ALU_SUB, 32'hDEAD_BEEF, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp valid_o", {31'b0, valid_o}, 32'd1);
            chk("bp result_o", result_o, 32'd7);
            chk("bp ready_o", {31'b0, ready_o}, 32'd0);
            if (i < 4) tick();
        end
        ready_i = 1'b1;
        drive(1'b1, ALU_ADDI, 32'd100, 32'd23);
        #1;
        chk("bp release ready_o", {31'b0, ready_o}, 32'd1);
        check_result("add_bp");
        push(32'd123, 1'b0, 1'b0);
        tick();
        check_result("addi_after_bp");
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();

        // Illegal code, then a legal op clears the flag.
        drive(1'b1, 4'b1100, 32'd5, 32'd6);
        push(32'd0, 1'b1, 1'b1);
        tick();
        check_result("illegal");
        drive(1'b1, ALU_ADD, 32'd1, 32'd1);
        push(32'd2, 1'b0, 1'b0);
        tick();
        check_result("legal_after_illegal");
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();

        // Reset in the middle of a MUL.
        drive(1'b1, ALU_MUL, 32'd3, 32'd5);
        tick();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        repeat (9) tick();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("mulrst valid_o", {31'b0, valid_o}, 32'd0);
        chk("mulrst result_o", result_o, 32'd0);
        chk("mulrst zero_o", {31'b0, zero_o}, 32'd1);
        chk("mulrst ready_o", {31'b0, ready_o}, 32'd1);
        rises = 0;
        repeat (40) begin
            tick();
            if (valid_o !== 1'b0) rises++;
        end
        chk("mulrst aborted valid_o", rises, 32'd0);
        drive(1'b1, ALU_ADD, 32'd9, 32'd8);
        push(32'h11, 1'b0, 1'b0);
        tick();
        check_result("add_after_mulrst");
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();
        chk("final sb empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
